// File: rtl/wb_sequencer_pkg.sv
// Shared constants and the writeback entry payload for the writeback sequencer.
//   FIFO_DEPTH : entries in the writeback buffer
//   ADDR_W     : register-address width
//   DATA_W     : register data width
//   wb_entry_t : {rd, data, is_load} as held in the writeback buffer
package wb_sequencer_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 1 << ADDR_W;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              is_load;
  } wb_entry_t;

endpackage

// File: rtl/wb_sequencer_if.sv
// Writeback sequencer bus bundle.
//   ex_*    : ALU writeback request (valid/ready)
//   mem_*   : load writeback request (valid/ready)
//   issue_* : load issue notification, marks rd pending
//   wb_en   : drain enable
//   rs1/rs2/stall : decode-stage hazard query
//   rf_*    : register-file write port (address, data, enable)
// master = requester/decode side, slave = sequencer.
interface wb_sequencer_if;
  import wb_sequencer_pkg::*;

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_data;
  logic              ex_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;

  logic              wb_en;

  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              stall;

  logic [ADDR_W-1:0] rf_write;
  logic [DATA_W-1:0] rf_data;
  logic              rf_RW;

  modport master (
    output ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd, wb_en, rs1, rs2,
    input  ex_ready, mem_ready, stall, rf_write, rf_data, rf_RW
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd, wb_en, rs1, rs2,
    output ex_ready, mem_ready, stall, rf_write, rf_data, rf_RW
  );

endinterface

// File: rtl/wb_fifo.sv
// Small shift-style writeback buffer; slot 0 is always the head.
//   clk, rst     : clock, synchronous active-low reset
//   push, din    : write an entry (ignored when full)
//   pop          : drop the head (ignored when empty)
//   head         : current head entry
//   entries      : all slots, qualified by entry_valid (for hazard checks)
//   full, empty, count : occupancy
module wb_fifo
  import wb_sequencer_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  wb_entry_t                       din,
  input  logic                            pop,
  output wb_entry_t                       head,
  output wb_entry_t [FIFO_DEPTH-1:0]      entries,
  output logic      [FIFO_DEPTH-1:0]      entry_valid,
  output logic                            full,
  output logic                            empty,
  output logic      [CNT_W-1:0]           count
);

  wb_entry_t [FIFO_DEPTH-1:0] slots, slots_n;
  logic      [CNT_W-1:0]      count_n;
  logic                       push_ok, pop_ok;
  logic      [PTR_W-1:0]      wr_idx;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[0];
  assign entries = slots;

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entry_valid[i] = (count > CNT_W'(i));
    end
  end

  // Pop shifts toward slot 0; the push lands after the surviving entries.
  always_comb begin
    slots_n = slots;
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    wr_idx  = pop_ok ? PTR_W'(count - CNT_W'(1)) : PTR_W'(count);
    if (pop_ok) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        slots_n[i] = slots[i+1];
      end
    end
    if (push_ok) begin
      slots_n[wr_idx] = din;
    end
    count_n = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slots <= '0;
      count <= '0;
    end else begin
      slots <= slots_n;
      count <= count_n;
    end
  end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: arbitrates ALU and load writebacks into a small buffer,
// drains it to the register file, and tracks pending loads for hazard stalls.
//   clk, rst : clock, synchronous active-low reset
//   bus      : wb_sequencer_if.slave (requests, drain enable, hazard query, rf port)
module wb_sequencer
  import wb_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  wb_sequencer_if.slave  bus
);

  wb_entry_t                  push_entry;
  wb_entry_t                  head;
  wb_entry_t [FIFO_DEPTH-1:0] entries;
  logic      [FIFO_DEPTH-1:0] entry_valid;
  logic                       full, empty;
  logic      [CNT_W-1:0]      count;
  logic                       mem_fire, ex_fire, push, pop;

  logic [NUM_REGS-1:0] busy, busy_n;
  logic [ADDR_W-1:0]   rf_write_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic                rf_we_q;
  logic                rs1_hit, rs2_hit;

  // Loads have priority; only one request is taken per cycle.
  assign bus.mem_ready = ~full;
  assign bus.ex_ready  = ~full & ~bus.mem_valid;
  assign mem_fire      = bus.mem_valid & bus.mem_ready;
  assign ex_fire       = bus.ex_valid & bus.ex_ready;

  always_comb begin
    push_entry = '0;
    if (mem_fire) begin
      push_entry = '{rd: bus.mem_rd, data: bus.mem_data, is_load: 1'b1};
    end else begin
      push_entry = '{rd: bus.ex_rd, data: bus.ex_data, is_load: 1'b0};
    end
  end

  // Writes to x0 complete the handshake but are never buffered.
  assign push = (mem_fire | ex_fire) & (push_entry.rd != '0);
  assign pop  = bus.wb_en & ~empty;

  wb_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .din         (push_entry),
    .pop         (pop),
    .head        (head),
    .entries     (entries),
    .entry_valid (entry_valid),
    .full        (full),
    .empty       (empty),
    .count       (count)
  );

  // Register-file write port: one-cycle enable per pop, address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_write_q <= '0;
      rf_data_q  <= '0;
    end else begin
      rf_we_q <= pop;
      if (pop) begin
        rf_write_q <= head.rd;
        rf_data_q  <= head.data;
      end
    end
  end

  assign bus.rf_RW    = rf_we_q;
  assign bus.rf_write = rf_write_q;
  assign bus.rf_data  = rf_data_q;

  // Pending-load scoreboard; a new issue to the same rd outranks the retiring load.
  always_comb begin
    busy_n = busy;
    if (pop && head.is_load) begin
      busy_n[head.rd] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != '0)) begin
      busy_n[bus.issue_rd] = 1'b1;
    end
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_n;
    end
  end

  // Hazard: pending load or an unwritten buffered value; the rf port itself is not a hazard.
  always_comb begin
    rs1_hit = (bus.rs1 != '0) && busy[bus.rs1];
    rs2_hit = (bus.rs2 != '0) && busy[bus.rs2];
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        if ((bus.rs1 != '0) && (entries[i].rd == bus.rs1)) rs1_hit = 1'b1;
        if ((bus.rs2 != '0) && (entries[i].rd == bus.rs2)) rs2_hit = 1'b1;
      end
    end
  end

  assign bus.stall = rs1_hit | rs2_hit;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer.
module tb_wb_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_sequencer_if bus ();

  wb_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid    = 1'b0;
    bus.ex_rd       = '0;
    bus.ex_data     = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = '0;
    bus.mem_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wb_en = 1'b1;
    idle_inputs();
    step();
    step();
    checks += 6;
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL reset_rf_RW: got %0b expected 0", bus.rf_RW); end
    if (bus.rf_write !== 5'd0) begin errors++; $display("FAIL reset_rf_write: got %0d expected 0", bus.rf_write); end
    if (bus.rf_data !== 32'd0) begin errors++; $display("FAIL reset_rf_data: got %0h expected 0", bus.rf_data); end
    if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %0b expected 1", bus.ex_ready); end
    if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %0b expected 1", bus.mem_ready); end
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", bus.stall); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    bus.wb_en    = 1'b1;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd5;
    bus.ex_data  = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL single_ex_ready: got %0b expected 1", bus.ex_ready); end
    step();  // accepted
    bus.ex_valid = 1'b0;
    checks++;
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL single_early_RW: got %0b expected 0", bus.rf_RW); end
    step();  // popped
    checks += 3;
    if (bus.rf_RW !== 1'b1) begin errors++; $display("FAIL single_RW: got %0b expected 1", bus.rf_RW); end
    if (bus.rf_write !== 5'd5) begin errors++; $display("FAIL single_rf_write: got %0d expected 5", bus.rf_write); end
    if (bus.rf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf_data: got %0h expected deadbeef", bus.rf_data); end
    step();
    checks += 2;
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL single_RW_one_cycle: got %0b expected 0", bus.rf_RW); end
    if (bus.rf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data_hold: got %0h expected deadbeef", bus.rf_data); end
  endtask

  task automatic test_arbitration();
    bus.wb_en     = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd3;
    bus.mem_data  = 32'h0000_0033;
    bus.ex_valid  = 1'b1;
    bus.ex_rd     = 5'd4;
    bus.ex_data   = 32'h0000_0044;
    #1;
    checks += 2;
    if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL arb_mem_ready: got %0b expected 1", bus.mem_ready); end
    if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL arb_ex_blocked: got %0b expected 0", bus.ex_ready); end
    step();  // mem accepted
    bus.mem_valid = 1'b0;
    #1;
    checks++;
    if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL arb_ex_ready_after: got %0b expected 1", bus.ex_ready); end
    step();  // ex accepted, mem entry popped
    bus.ex_valid = 1'b0;
    checks += 3;
    if (bus.rf_RW !== 1'b1) begin errors++; $display("FAIL arb_first_RW: got %0b expected 1", bus.rf_RW); end
    if (bus.rf_write !== 5'd3) begin errors++; $display("FAIL arb_first_rd: got %0d expected 3", bus.rf_write); end
    if (bus.rf_data !== 32'h33) begin errors++; $display("FAIL arb_first_data: got %0h expected 33", bus.rf_data); end
    step();
    checks += 3;
    if (bus.rf_RW !== 1'b1) begin errors++; $display("FAIL arb_second_RW: got %0b expected 1", bus.rf_RW); end
    if (bus.rf_write !== 5'd4) begin errors++; $display("FAIL arb_second_rd: got %0d expected 4", bus.rf_write); end
    if (bus.rf_data !== 32'h44) begin errors++; $display("FAIL arb_second_data: got %0h expected 44", bus.rf_data); end
    step();
    checks++;
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL arb_idle_RW: got %0b expected 0", bus.rf_RW); end
  endtask

  task automatic test_hazard();
    bus.wb_en       = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    step();
    bus.issue_valid = 1'b0;
    bus.rs1         = 5'd7;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL hazard_rs1_busy: got %0b expected 1", bus.stall); end
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd7;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL hazard_rs2_busy: got %0b expected 1", bus.stall); end
    bus.rs2 = 5'd8;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL hazard_rs2_other: got %0b expected 0", bus.stall); end
    bus.rs2 = 5'd0;
    bus.rs1 = 5'd7;
    step();
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL hazard_still_busy: got %0b expected 1", bus.stall); end
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd7;
    bus.mem_data  = 32'h0000_0077;
    step();  // load pushed
    bus.mem_valid = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL hazard_buffered: got %0b expected 1", bus.stall); end
    step();  // load popped, busy[7] cleared
    checks += 3;
    if (bus.rf_RW !== 1'b1) begin errors++; $display("FAIL hazard_load_RW: got %0b expected 1", bus.rf_RW); end
    if (bus.rf_write !== 5'd7) begin errors++; $display("FAIL hazard_load_rd: got %0d expected 7", bus.rf_write); end
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL hazard_cleared: got %0b expected 0", bus.stall); end
    bus.rs1 = 5'd0;
  endtask

  task automatic test_backpressure();
    bus.wb_en    = 1'b0;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd10;
    bus.ex_data  = 32'h0000_00A0;
    step();
    bus.ex_rd   = 5'd11;
    bus.ex_data = 32'h0000_00B0;
    #1;
    checks++;
    if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL bp_second_ready: got %0b expected 1", bus.ex_ready); end
    step();
    bus.ex_rd   = 5'd12;
    bus.ex_data = 32'h0000_00C0;
    bus.rs1     = 5'd11;
    #1;
    checks += 4;
    if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL bp_third_blocked: got %0b expected 0", bus.ex_ready); end
    if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL bp_mem_blocked: got %0b expected 0", bus.mem_ready); end
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL bp_fifo_hazard: got %0b expected 1", bus.stall); end
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL bp_frozen_RW: got %0b expected 0", bus.rf_RW); end
    bus.rs1 = 5'd0;
    step();
    checks++;
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL bp_frozen_RW2: got %0b expected 0", bus.rf_RW); end
    bus.wb_en = 1'b1;
    step();  // pop 10
    checks += 3;
    if (bus.rf_RW !== 1'b1) begin errors++; $display("FAIL bp_w1_RW: got %0b expected 1", bus.rf_RW); end
    if (bus.rf_write !== 5'd10) begin errors++; $display("FAIL bp_w1_rd: got %0d expected 10", bus.rf_write); end
    if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_again: got %0b expected 1", bus.ex_ready); end
    step();  // pop 11, push 12
    bus.ex_valid = 1'b0;
    checks += 2;
    if (bus.rf_write !== 5'd11) begin errors++; $display("FAIL bp_w2_rd: got %0d expected 11", bus.rf_write); end
    if (bus.rf_data !== 32'hB0) begin errors++; $display("FAIL bp_w2_data: got %0h expected b0", bus.rf_data); end
    step();
    checks += 3;
    if (bus.rf_RW !== 1'b1) begin errors++; $display("FAIL bp_w3_RW: got %0b expected 1", bus.rf_RW); end
    if (bus.rf_write !== 5'd12) begin errors++; $display("FAIL bp_w3_rd: got %0d expected 12", bus.rf_write); end
    if (bus.rf_data !== 32'hC0) begin errors++; $display("FAIL bp_w3_data: got %0h expected c0", bus.rf_data); end
    step();
    checks++;
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b expected 0", bus.rf_RW); end
  endtask

  task automatic test_rd_zero();
    bus.wb_en    = 1'b1;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd0;
    bus.ex_data  = 32'h0000_1234;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    #1;
    checks++;
    if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0b expected 1", bus.ex_ready); end
    step();
    bus.ex_valid    = 1'b0;
    bus.issue_valid = 1'b0;
    bus.rs1         = 5'd0;
    #1;
    checks += 3;
    if (dut.count !== 2'd0) begin errors++; $display("FAIL x0_not_pushed: got %0d expected 0", dut.count); end
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL x0_RW_a: got %0b expected 0", bus.rf_RW); end
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0b expected 0", bus.stall); end
    step();
    checks++;
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL x0_RW_b: got %0b expected 0", bus.rf_RW); end
  endtask

  task automatic test_reset_mid();
    bus.wb_en       = 1'b0;
    bus.ex_valid    = 1'b1;
    bus.ex_rd       = 5'd20;
    bus.ex_data     = 32'h0000_0020;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    step();
    bus.issue_valid = 1'b0;
    bus.ex_rd       = 5'd21;
    bus.ex_data     = 32'h0000_0021;
    step();
    bus.ex_rd   = 5'd22;
    bus.ex_data = 32'h0000_0022;
    #1;
    checks++;
    if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: got %0b expected 0", bus.ex_ready); end
    rst = 1'b0;
    bus.wb_en = 1'b1;
    step();  // reset edge with data buffered and a request in flight
    rst = 1'b1;
    bus.ex_valid = 1'b0;
    bus.rs1      = 5'd9;
    bus.rs2      = 5'd20;
    #1;
    checks += 6;
    if (dut.count !== 2'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", dut.count); end
    if (dut.busy !== 32'd0) begin errors++; $display("FAIL rmid_busy: got %0h expected 0", dut.busy); end
    if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL rmid_RW: got %0b expected 0", bus.rf_RW); end
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %0b expected 0", bus.stall); end
    if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL rmid_ex_ready: got %0b expected 1", bus.ex_ready); end
    if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rmid_mem_ready: got %0b expected 1", bus.mem_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.rf_RW !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse[%0d]: got %0b expected 0", i, bus.rf_RW); end
    end
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.wb_en = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_arbitration();
    test_hazard();
    test_backpressure();
    test_rd_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset (rst=0 at a clk edge resets).
REQ-003 SHALL have ports ex_valid in 1, ex_rd in 5, ex_data in 32, ex_ready out 1: ALU writeback request.
REQ-004 SHALL have ports mem_valid in 1, mem_rd in 5, mem_data in 32, mem_ready out 1: load writeback request.
REQ-005 SHALL have ports issue_valid in 1, issue_rd in 5: load issued; marks rd pending.
REQ-006 SHALL have port wb_en, input, 1, drain enable; 0 freezes register-file writes.
REQ-007 SHALL have ports rs1 in 5, rs2 in 5, stall out 1: hazard query for the decode stage.
REQ-008 SHALL have ports rf_write out 5, rf_data out 32, rf_RW out 1: drive the register-file write port (address, data, enable).

Function
REQ-009 SHALL buffer accepted writes in a 2-entry FIFO; entry = {rd[4:0], data[31:0], is_load}.
REQ-010 SHALL accept mem over ex when both are valid: mem_ready = (count<2); ex_ready = (count<2) & ~mem_valid.
REQ-011 SHALL accept at most one request per cycle; a transfer occurs when valid & ready are both 1 at the edge.
REQ-012 SHALL complete the handshake for a request with rd=0 but not push it; a load with rd=0 needs no scoreboard clear.
REQ-013 SHALL pop the FIFO head into registered outputs at an edge where wb_en=1 and count>0: rf_RW=1, rf_write=head.rd, rf_data=head.data for exactly one cycle.
REQ-014 SHALL drive rf_RW=0 in every cycle that follows an edge with no pop; rf_write/rf_data then hold their last values.
REQ-015 SHALL give a latency of 2 edges with empty FIFO and wb_en=1: accepted at edge N, rf_RW=1 in the cycle after edge N+1.
REQ-016 SHALL allow push and pop at the same edge; count is unchanged and FIFO order is preserved.
REQ-017 SHALL keep a 32-bit busy scoreboard; issue_valid with issue_rd!=0 sets busy[issue_rd].
REQ-018 SHALL clear busy[rd] at the edge a head entry with is_load=1 is popped.
REQ-019 SHALL let set win over clear at the same edge when the indices match; busy[0] is constant 0.
REQ-020 SHALL drive stall combinationally: 1 iff a nonzero rs1 or rs2 is busy or equals the rd of a valid FIFO entry.
REQ-021 SHALL not treat a value on the rf outputs (already written this cycle) as a hazard.

Reset
REQ-022 SHALL, at an edge with rst=0: count=0, busy=0, rf_RW=0, rf_write=0, rf_data=0; ex_ready and mem_ready are then 1.
REQ-023 SHALL discard FIFO contents and in-flight handshakes on reset mid-operation; no rf_RW pulse follows the reset edge.

Structure
REQ-024 SHALL place FIFO depth (2), register-address width (5) and data width (32) as constants in the shared core package, alongside the writeback entry struct.
REQ-025 SHALL implement the FIFO as one sub-module, wb_fifo (push/pop/full/empty/count); arbitration, scoreboard and hazard logic stay in wb_sequencer.

Verification
REQ-026 SHALL test: reset, then ex_valid=1, ex_rd=5, ex_data=0xDEADBEEF, wb_en=1 -> rf_RW=1, rf_write=5, rf_data=0xDEADBEEF two edges later, for one cycle.
REQ-027 SHALL test: mem_valid and ex_valid in the same cycle (mem_rd=3, ex_rd=4) -> mem accepted, ex_ready=0; writes then appear in order 3, 4.
REQ-028 SHALL test: issue_valid, issue_rd=7, then rs1=7 -> stall=1 until the popped load to x7 clears busy; stall=0 the next cycle.
REQ-029 SHALL test: wb_en=0 with three ex requests -> two accepted, ex_ready=0 on the third; set wb_en=1 -> all three written in order.
REQ-030 SHALL test: ex_rd=0 with ex_data=0x1234 -> handshake completes and rf_RW stays 0; rs1=0 -> stall=0.
REQ-031 SHALL test: rst=0 asserted while the FIFO holds two entries -> count=0, busy=0, and no rf_RW pulse afterward.
